load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/lsu_load_align.sv | 44 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_t : controller states
//   lsu_size_t  : access width decoded from funct3
//   lsu_bus_t   : latched data-memory request payload
//   helpers     : size decode, misalignment check, byte enables, store lane replication
package lsu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } lsu_bus_t;

   // Stores only know SB/SH; the unsigned load encodings fall back to word for stores.
   function automatic lsu_size_t lsu_size(input logic [2:0] funct3, input logic we);
      if (funct3 == F3_B || (!we && funct3 == F3_BU))      return SZ_B;
      else if (funct3 == F3_H || (!we && funct3 == F3_HU)) return SZ_H;
      else                                                 return SZ_W;
   endfunction

   function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
      case (size)
         SZ_H:    return addr_lo[0];
         SZ_W:    return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] lsu_byte_en(input lsu_size_t size, input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 4'b0001 << addr_lo;
         SZ_H:    return 4'b0011 << {addr_lo[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] lsu_store_data(input lsu_size_t size, input logic [XLEN-1:0] wdata);
      case (size)
         SZ_B:    return {4{wdata[7:0]}};
         SZ_H:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: selects the addressed byte/half of the bus word
// and sign- or zero-extends it according to funct3.
//   i_rdata   : word returned by data memory
//   i_addr_lo : byte offset within the word
//   i_funct3  : RV32I load width/sign field
//   o_result  : extended load value
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_addr_lo,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte lane select.
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   // Extension; unlisted encodings return the whole word.
   always_comb begin
      o_result = i_rdata;
      case (i_funct3)
         F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_result = {24'h000000, w_byte};
         F3_H:    o_result = {{16{w_half[15]}}, w_half};
         F3_HU:   o_result = {16'h0000, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns an execute-stage load/store into one word-aligned
// req/ack transaction, stalls the pipeline meanwhile, and returns the extended load.
//   ex_*         : operation from the execute-stage register
//   lsu_stall    : hold PC and pipeline registers (combinational in the accept cycle)
//   lsu_done     : one-cycle completion pulse; lsu_misalign / lsu_timeout qualify it
//   lsu_rdata    : registered load result, held until the next completion
//   dmem_*       : data-memory request/acknowledge port
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_rd,
   input  logic            ex_wr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_addr,
   input  logic [XLEN-1:0] ex_wdata,
   output logic            lsu_stall,
   output logic            lsu_done,
   output logic [XLEN-1:0] lsu_rdata,
   output logic            lsu_misalign,
   output logic            lsu_timeout,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [BE_W-1:0] dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

   lsu_state_t       r_state;
   lsu_bus_t         r_bus;
   logic             r_req;
   logic [1:0]       r_addr_lo;
   logic [2:0]       r_funct3;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_done;
   logic             r_misalign;
   logic             r_timeout;
   logic [XLEN-1:0]  r_rdata;

   logic             w_accept;
   logic             w_we;
   lsu_size_t        w_size;
   logic             w_misalign;
   logic [XLEN-1:0]  w_load_data;

   // Accept decode; a load takes priority when both rd and wr are set.
   assign w_accept   = (r_state == IDLE) && ex_valid && (ex_rd || ex_wr);
   assign w_we       = ex_wr && !ex_rd;
   assign w_size     = lsu_size(ex_funct3, w_we);
   assign w_misalign = lsu_misaligned(w_size, ex_addr[1:0]);

   lsu_load_align u_load_align (
      .i_rdata   (dmem_rdata),
      .i_addr_lo (r_addr_lo),
      .i_funct3  (r_funct3),
      .o_result  (w_load_data)
   );

   // Controller and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_bus      <= '0;
         r_req      <= 1'b0;
         r_addr_lo  <= 2'b00;
         r_funct3   <= 3'b000;
         r_wait_cnt <= '0;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr_lo  <= ex_addr[1:0];
                  r_funct3   <= ex_funct3;
                  r_wait_cnt <= '0;
                  if (w_misalign) begin
                     // No bus cycle; complete straight away with zero data.
                     r_state    <= DONE;
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                     r_rdata    <= '0;
                  end else begin
                     r_state     <= REQ;
                     r_req       <= 1'b1;
                     r_bus.we    <= w_we;
                     r_bus.addr  <= {ex_addr[XLEN-1:2], 2'b00};
                     r_bus.be    <= lsu_byte_en(w_size, ex_addr[1:0]);
                     r_bus.wdata <= lsu_store_data(w_size, ex_wdata);
                  end
               end
            end
            REQ: begin
               // Ack wins over timeout when both land in the last wait cycle.
               if (dmem_ack) begin
                  r_state  <= DONE;
                  r_req    <= 1'b0;
                  r_bus.we <= 1'b0;
                  r_done   <= 1'b1;
                  if (!r_bus.we) begin
                     r_rdata <= w_load_data;
                  end
               end else if (r_wait_cnt == LAST_WAIT) begin
                  r_state   <= DONE;
                  r_req     <= 1'b0;
                  r_bus.we  <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_wait_cnt <= CNT_W'(r_wait_cnt + 1'b1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign lsu_stall    = w_accept || (r_state == REQ);
   assign lsu_done     = r_done;
   assign lsu_misalign = r_misalign;
   assign lsu_timeout  = r_timeout;
   assign lsu_rdata    = r_rdata;
   assign dmem_req     = r_req;
   assign dmem_we      = r_bus.we;
   assign dmem_addr    = r_bus.addr;
   assign dmem_be      = r_bus.be;
   assign dmem_wdata   = r_bus.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// loads/stores with random ack latency, checked against a behavioural model.
module tb_load_store_unit;

   localparam int unsigned MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
   logic        lsu_stall, lsu_done, lsu_misalign, lsu_timeout;
   logic [31:0] lsu_rdata;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_rdata = 32'd0;

   load_store_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_funct3(ex_funct3),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misalign(lsu_misalign), .lsu_timeout(lsu_timeout),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Access width in bytes as an RV32I core sees it.
   function automatic int unsigned acc_bytes(input logic is_load, input logic [2:0] f3);
      if (f3 == 3'd0 || (is_load && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (is_load && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   // Reference load result from plain shifts and arithmetic.
   function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] a);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
         3'd4:    return b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // One operation from accept to DONE; delay = no-ack REQ cycles before ack (>= MW -> timeout).
   task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned delay, input logic [31:0] rword);
      logic        is_load;
      int unsigned nb, stalls, exp_stalls;
      logic        mis, tmo;
      logic [31:0] exp_be, exp_wd;
      is_load = rd;
      nb      = acc_bytes(is_load, f3);
      mis     = (addr % nb) != 0;
      tmo     = !mis && (delay >= MW);
      exp_be  = (nb == 1) ? (32'd1 << addr[1:0]) : (nb == 2) ? (32'd3 << (2 * addr[1])) : 32'hF;
      exp_wd  = (nb == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
      ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
      stalls = 0;
      @(negedge clk);
      check("accept_stall", 32'(lsu_stall), 32'd1);
      check("accept_noreq", 32'(dmem_req), 32'd0);
      stalls += 32'(lsu_stall);
      @(posedge clk); #1;
      if (!mis) begin
         for (int unsigned k = 0; k < MW; k++) begin
            dmem_ack   = (k == delay);
            dmem_rdata = (k == delay) ? rword : $urandom;
            @(negedge clk);
            check("req_high", 32'(dmem_req), 32'd1);
            check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_we", 32'(dmem_we), 32'(!is_load));
            if (!is_load) begin
               check("req_be", 32'(dmem_be), exp_be);
               check("req_wdata", dmem_wdata, exp_wd);
            end
            stalls += 32'(lsu_stall);
            @(posedge clk); #1;
            if (k == delay) break;
         end
         dmem_ack = 1'b0;
      end
      if (mis || tmo)    exp_rdata = 32'd0;
      else if (is_load)  exp_rdata = load_ref(f3, rword, addr[1:0]);
      exp_stalls = mis ? 1 : (tmo ? 1 + MW : 2 + delay);
      @(negedge clk);
      check("done_pulse", 32'(lsu_done), 32'd1);
      check("done_stall", 32'(lsu_stall), 32'd0);
      check("done_noreq", 32'(dmem_req), 32'd0);
      check("done_misalign", 32'(lsu_misalign), 32'(mis));
      check("done_timeout", 32'(lsu_timeout), 32'(tmo));
      check("done_rdata", lsu_rdata, exp_rdata);
      check("stall_cycles", stalls, exp_stalls);
      @(posedge clk); #1;
      ex_valid = 1'b0;
   endtask

   // Idle cycles with stray acks and non-memory instructions: nothing may happen.
   task automatic idle_cycles(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         ex_valid = $urandom_range(0, 1); ex_rd = 1'b0; ex_wr = 1'b0;
         dmem_ack = $urandom_range(0, 1); dmem_rdata = $urandom;
         @(negedge clk);
         check("idle_stall", 32'(lsu_stall), 32'd0);
         check("idle_req", 32'(dmem_req), 32'd0);
         check("idle_done", 32'(lsu_done), 32'd0);
         check("idle_rdata_hold", lsu_rdata, exp_rdata);
         @(posedge clk); #1;
      end
      ex_valid = 1'b0; dmem_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned op;
      // Reset values.
      #12;
      check("rst_stall", 32'(lsu_stall), 32'd0);
      check("rst_done", 32'(lsu_done), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_rdata", lsu_rdata, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed scenarios.
      do_op(1, 0, 3'd0, 32'h0000_1003, 32'h0, 0, 32'h8012_3456);
      check("lb_value", lsu_rdata, 32'hFFFF_FF80);
      do_op(0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0);
      do_op(1, 0, 3'd2, 32'h0000_3001, 32'h0, 0, 32'h0);
      do_op(1, 0, 3'd5, 32'h0000_4002, 32'h0, 0, 32'hBEEF_0000);
      check("lhu_value", lsu_rdata, 32'h0000_BEEF);
      do_op(1, 0, 3'd4, 32'h0000_4001, 32'h0, 1, 32'h0000_AB00);
      check("lbu_value", lsu_rdata, 32'h0000_00AB);
      do_op(1, 0, 3'd2, 32'h0000_5000, 32'h0, 10, 32'h0);
      do_op(1, 1, 3'd2, 32'h0000_5004, 32'h0, 2, 32'hCAFE_F00D);
      idle_cycles(3);

      // Reset in the middle of a request.
      ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h0000_6000;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_req", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", 32'(dmem_req), 32'd0);
      check("rst_mid_done", 32'(lsu_done), 32'd0);
      check("rst_mid_stall", 32'(lsu_stall), 32'd0);
      exp_rdata = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_done", 32'(lsu_done), 32'd0);
      @(posedge clk); #1;
      do_op(1, 0, 3'd2, 32'h0000_6004, 32'h0, 0, 32'h1357_9BDF);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 2);
         do_op(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom_range(0, MW + 1), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
